// File: rtl/fifo_rx_pkg.sv
// Shared types and defaults for the FT245 receive path (fifo_rx).
// Build option: FIFO_RX_BUFFER_EN selects a 4-entry store instead of a holding register.
package fifo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int SYNC_STAGES_DEF       = 2;
    localparam int RD_PULSE_CYCLES_DEF   = 3;
    localparam int RD_RECOVER_CYCLES_DEF = 3;
    localparam int BUF_DEPTH             = 4;

endpackage

// File: rtl/fifo_rx_buf.sv
// Output store for fifo_rx: holding register by default, or a 4-entry circular
// buffer when FIFO_RX_BUFFER_EN is defined.
module fifo_rx_buf
    import fifo_rx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data_in,
    output logic       space,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

`ifdef FIFO_RX_BUFFER_EN
    logic [7:0] r_mem [BUF_DEPTH];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_cnt;
    logic       w_pop;

    assign w_pop     = (r_cnt != 3'd0) && out_ready;
    assign space     = r_cnt < 3'(BUF_DEPTH);
    assign out_valid = r_cnt != 3'd0;
    assign out_data  = r_mem[r_rp];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (push) begin
                r_mem[r_wp] <= data_in;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            case ({push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
`else
    logic [7:0] r_data;
    logic       r_valid;

    // A pop frees the register in the same cycle, so a capture may land on it.
    assign space     = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (push) begin
            r_data  <= data_in;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/fifo_rx.sv
// FT245 asynchronous-FIFO receive engine: synchronizes RXF#, strobes RD#, captures
// bytes into fifo_rx_buf (depth set by FIFO_RX_BUFFER_EN).
module fifo_rx
    import fifo_rx_pkg::*;
#(
    parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
    parameter int RD_PULSE_CYCLES   = RD_PULSE_CYCLES_DEF,
    parameter int RD_RECOVER_CYCLES = RD_RECOVER_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_rxf_n,
    input  logic [7:0] fifo_d,
    output logic       fifo_rd_n,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxf_s;
    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic                   r_rd_n, w_rd_n_nxt;
    logic                   w_push;
    logic                   w_space;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], fifo_rxf_n};
    end
    assign w_rxf_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rd_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd_n  <= w_rd_n_nxt;
        end
    end

    // RD# is registered from the next state, so it falls on the edge that enters STROBE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_n_nxt  = 1'b1;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxf_s && w_space) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = 4'd0;
                    w_rd_n_nxt  = 1'b0;
                end
            end
            STROBE: begin
                if (r_cnt == 4'(RD_PULSE_CYCLES - 1)) begin
                    w_state_nxt = RECOVER;
                    w_cnt_nxt   = 4'd0;
                    w_push      = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + 4'd1;
                    w_rd_n_nxt = 1'b0;
                end
            end
            RECOVER: begin
                if (r_cnt == 4'(RD_RECOVER_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    fifo_rx_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .data_in   (fifo_d),
        .space     (w_space),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign fifo_rd_n = r_rd_n;
    assign busy      = r_state != IDLE;

endmodule

// File: tb/tb_fifo_rx.sv
// Directed bench for fifo_rx with a behavioural FT245 source and a byte sink monitor.
module tb_fifo_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_rxf_n = 1'b1;
    logic [7:0] fifo_d = 8'h00;
    logic       fifo_rd_n;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    always #5 clock = ~clock;

    fifo_rx dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_rxf_n (fifo_rxf_n),
        .fifo_d     (fifo_d),
        .fifo_rd_n  (fifo_rd_n),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // FT245 source model: bytes queued in src, consumed on each RD# rising edge.
    logic [7:0] src[$];
    int         rd_idx = 0;
    int         rd_count = 0;
    logic       m_low = 1'b0;
    logic       m_hold = 1'b0;
    logic       g_glitch = 1'b0;

    always @(fifo_rd_n) begin
        if (fifo_rd_n === 1'b0) begin
            m_low = 1'b1;
            rd_count++;
            if (src.size() > rd_idx) fifo_d = src[rd_idx];
        end else if (fifo_rd_n === 1'b1 && m_low) begin
            m_low = 1'b0;
            if (src.size() > rd_idx) rd_idx++;
            m_hold = 1'b1;
            #15;
            m_hold = 1'b0;
        end
    end

    always begin
        #1;
        fifo_rxf_n = (m_hold || (src.size() <= rd_idx)) && !g_glitch;
    end

    // Sink monitor
    logic [7:0] rcv[$];
    int         rcv_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            rcv.push_back(out_data);
            rcv_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        src.push_back(b);
    endtask

    task automatic wait_rcv(input int n, input int bound, input string name);
        int k = 0;
        while (rcv.size() < n && k < bound) begin
            step(1);
            k++;
        end
        chk(name, rcv.size(), n);
    endtask

    typedef struct {
        logic [7:0] d;
        int         exp_lat;
        int         exp_low;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vec[5];

    initial begin
        int b;
        int r0;
        int n;

        vec[0] = '{8'hA5, 3, 3, 8'hA5};
        vec[1] = '{8'h00, 3, 3, 8'h00};
        vec[2] = '{8'hFF, 3, 3, 8'hFF};
        vec[3] = '{8'h5A, 3, 3, 8'h5A};
        vec[4] = '{8'h3C, 3, 3, 8'h3C};

        step(3);
        chk("rst_rd_n", int'(fifo_rd_n), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step(3);

        // Single-byte reads: RXF# fall to RD# low, RD# width, one-cycle delivery
        for (int i = 0; i < 5; i++) begin
            int lat;
            int low;
            push_byte(vec[i].d);
            lat = 0;
            while (fifo_rd_n && lat < 20) begin
                step(1);
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, vec[i].exp_lat);
            low = 0;
            while (!fifo_rd_n && low < 20) begin
                step(1);
                low++;
            end
            chk($sformatf("v%0d_rd_low", i), low, vec[i].exp_low);
            chk($sformatf("v%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d_data", i), int'(out_data), int'(vec[i].exp_q));
            step(1);
            chk($sformatf("v%0d_valid_drop", i), int'(out_valid), 0);
            step(10);
        end

        // Burst of 16 with out_ready high
        b = rcv.size();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_rcv(b + 16, 250, "burst_count");
        if (rcv.size() >= b + 16) begin
            for (int k = 0; k < 16; k++)
                chk($sformatf("burst_byte%0d", k), int'(rcv[b+k]), k);
            for (int k = 1; k < 16; k++)
                chk($sformatf("burst_gap%0d", k), rcv_cyc[b+k] - rcv_cyc[b+k-1], 7);
        end
        step(10);

        // Backpressure
        out_ready = 1'b0;
        r0 = rd_count;
        b = rcv.size();
`ifdef FIFO_RX_BUFFER_EN
        for (int i = 0; i < 6; i++) push_byte(8'h41 + 8'(i));
        step(80);
        chk("bp_reads", rd_count - r0, 4);
        chk("bp_rd_n_high", int'(fifo_rd_n), 1);
        chk("bp_busy", int'(busy), 0);
        chk("bp_hold_data", int'(out_data), 8'h41);
        out_ready = 1'b1;
        wait_rcv(b + 6, 150, "bp_count");
        if (rcv.size() >= b + 6)
            for (int k = 0; k < 6; k++)
                chk($sformatf("bp_byte%0d", k), int'(rcv[b+k]), 8'h41 + k);
        chk("bp_total_reads", rd_count - r0, 6);
`else
        for (int i = 0; i < 3; i++) push_byte(8'h31 + 8'(i));
        step(60);
        chk("bp_reads", rd_count - r0, 1);
        chk("bp_rd_n_high", int'(fifo_rd_n), 1);
        chk("bp_busy", int'(busy), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_hold_data", int'(out_data), 8'h31);
        out_ready = 1'b1;
        wait_rcv(b + 3, 100, "pop_capture_count");
        if (rcv.size() >= b + 3)
            for (int k = 0; k < 3; k++)
                chk($sformatf("pop_capture_byte%0d", k), int'(rcv[b+k]), 8'h31 + k);
        chk("bp_total_reads", rd_count - r0, 3);
`endif
        step(10);

        // Reset during the 2nd STROBE cycle: first byte lost, second delivered
        b = rcv.size();
        push_byte(8'h11);
        push_byte(8'h22);
        n = 0;
        while (fifo_rd_n && n < 20) begin
            step(1);
            n++;
        end
        step(1);
        chk("mid_rst_pre_rd_n", int'(fifo_rd_n), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_n", int'(fifo_rd_n), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step(2);
        reset = 1'b0;
        wait_rcv(b + 1, 50, "post_rst_count");
        if (rcv.size() >= b + 1) chk("post_rst_byte", int'(rcv[b]), 8'h22);
        step(10);
        chk("post_rst_no_extra", rcv.size(), b + 1);

        // Sub-cycle RXF# glitch must not start a strobe
        r0 = rd_count;
        g_glitch = 1'b1;
        #3;
        g_glitch = 1'b0;
        step(20);
        chk("glitch_reads", rd_count - r0, 0);
        chk("glitch_busy", int'(busy), 0);

        // RXF# stays high through RECOVER after the last byte
        r0 = rd_count;
        b = rcv.size();
        push_byte(8'h77);
        step(30);
        chk("tail_reads", rd_count - r0, 1);
        chk("tail_count", rcv.size(), b + 1);
        if (rcv.size() >= b + 1) chk("tail_byte", int'(rcv[b]), 8'h77);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
